// File: rtl/ripple_cla_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit carry-lookahead slice per clock,
// carry registered between slices, start via en/ready handshake.
module ripple_cla_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic [WIDTH-1:0] Output,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             ready
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic             sub_reg;
  logic [CW-1:0]    cnt;
  logic             last;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] sum_sl;
  logic [CHUNK:0]   c;
  logic             c_la;
  logic             p_chain;

  // CLA slice on the current chunk: every carry is a flat sum of generate/
  // propagate products rather than a chain through the previous carry.
  always_comb begin
    a_sl    = a_reg[cnt*CHUNK +: CHUNK];
    b_sl    = b_reg[cnt*CHUNK +: CHUNK];
    g       = a_sl & b_sl;
    p       = a_sl ^ b_sl;
    c       = '0;
    c[0]    = carry;
    c_la    = 1'b0;
    p_chain = 1'b0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      c_la    = g[i];
      p_chain = p[i];
      for (int unsigned k = 0; k < i; k++) begin
        c_la    = c_la | (p_chain & g[i-1-k]);
        p_chain = p_chain & p[i-1-k];
      end
      c[i+1] = c_la | (p_chain & carry);
    end
    sum_sl   = p ^ c[CHUNK-1:0];
    res_next = res_reg;
    res_next[cnt*CHUNK +: CHUNK] = sum_sl;
  end

  assign last = (cnt == CW'(NCH - 1));

  // Control FSM plus datapath registers; outputs only move on completion or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      Output  <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      carry   <= 1'b0;
      sub_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            // Subtract as A + ~B + 1; c_in becomes a borrow by inverting it too.
            a_reg   <= A;
            b_reg   <= sub ? ~B : B;
            carry   <= c_in ^ sub;
            sub_reg <= sub;
            cnt     <= '0;
            res_reg <= '0;
            state   <= BUSY;
            ready   <= 1'b0;
          end
        end
        BUSY: begin
          res_reg <= res_next;
          carry   <= c[CHUNK];
          if (last) begin
            Output <= res_next;
            c_out  <= c[CHUNK] ^ sub_reg;
            ovf    <= c[CHUNK] ^ c[CHUNK-1];
            zero   <= (res_next == '0);
            cnt    <= '0;
            state  <= IDLE;
            ready  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ripple_cla_seq.sv
// Bench for ripple_cla_seq: three configurations (16/4, 16/16, 32/8) run the
// same directed vector table in lockstep, plus hand-written corner sequences.
module tb_ripple_cla_seq;

  logic        clk = 1'b0;
  logic        rst_n, en, sub, c_in;
  logic [15:0] A16, B16;
  logic [31:0] A32, B32;

  logic [15:0] o_a, o_b;
  logic [31:0] o_c;
  logic        co_a, v_a, z_a, rdy_a;
  logic        co_b, v_b, z_b, rdy_b;
  logic        co_c, v_c, z_c, rdy_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ripple_cla_seq #(.WIDTH(16), .CHUNK(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .sub(sub), .A(A16), .B(B16), .c_in(c_in),
    .Output(o_a), .c_out(co_a), .ovf(v_a), .zero(z_a), .ready(rdy_a));

  ripple_cla_seq #(.WIDTH(16), .CHUNK(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .sub(sub), .A(A16), .B(B16), .c_in(c_in),
    .Output(o_b), .c_out(co_b), .ovf(v_b), .zero(z_b), .ready(rdy_b));

  ripple_cla_seq #(.WIDTH(32), .CHUNK(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .sub(sub), .A(A32), .B(B32), .c_in(c_in),
    .Output(o_c), .c_out(co_c), .ovf(v_c), .zero(z_c), .ready(rdy_c));

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] o;
    logic        co;
    logic        v;
    logic        z;
  } vec_t;

  localparam int NV = 9;
  vec_t v16[NV];
  vec_t v32[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Pulse en for one cycle on all three units, wait for all to finish,
  // then check latency, output stability during BUSY and the results.
  task automatic run_op(input vec_t x16, input vec_t x32, input int idx);
    logic [15:0] po_a, po_b;
    logic [31:0] po_c;
    int la, lb, lc;
    logic st_ok;
    @(negedge clk);
    sub  = x16.s;
    c_in = x16.ci;
    A16  = x16.a[15:0];
    B16  = x16.b[15:0];
    A32  = x32.a;
    B32  = x32.b;
    en   = 1'b1;
    po_a = o_a;
    po_b = o_b;
    po_c = o_c;
    @(negedge clk);
    en = 1'b0;
    la = 0; lb = 0; lc = 0;
    st_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!rdy_a) begin la++; if (o_a !== po_a) st_ok = 1'b0; end
      if (!rdy_b) begin lb++; if (o_b !== po_b) st_ok = 1'b0; end
      if (!rdy_c) begin lc++; if (o_c !== po_c) st_ok = 1'b0; end
      if (rdy_a && rdy_b && rdy_c) break;
      @(negedge clk);
    end
    chk($sformatf("v%0d lat16x4", idx), 32'(la), 32'd4);
    chk($sformatf("v%0d lat16x16", idx), 32'(lb), 32'd1);
    chk($sformatf("v%0d lat32x8", idx), 32'(lc), 32'd4);
    chk($sformatf("v%0d busy_hold", idx), {31'd0, st_ok}, 32'd1);
    chk($sformatf("v%0d out16x4", idx), {16'd0, o_a}, x16.o);
    chk($sformatf("v%0d flg16x4", idx), {29'd0, co_a, v_a, z_a}, {29'd0, x16.co, x16.v, x16.z});
    chk($sformatf("v%0d out16x16", idx), {16'd0, o_b}, x16.o);
    chk($sformatf("v%0d flg16x16", idx), {29'd0, co_b, v_b, z_b}, {29'd0, x16.co, x16.v, x16.z});
    chk($sformatf("v%0d out32x8", idx), o_c, x32.o);
    chk($sformatf("v%0d flg32x8", idx), {29'd0, co_c, v_c, z_c}, {29'd0, x32.co, x32.v, x32.z});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy;
    //             s     a              b              ci    o              co    v     z
    v16[0] = '{1'b0, 32'h007F,     32'h007F,     1'b0, 32'h00FE,     1'b0, 1'b0, 1'b0};
    v16[1] = '{1'b0, 32'hFFFF,     32'h0001,     1'b0, 32'h0000,     1'b1, 1'b0, 1'b1};
    v16[2] = '{1'b0, 32'h7FFF,     32'h0001,     1'b0, 32'h8000,     1'b0, 1'b1, 1'b0};
    v16[3] = '{1'b1, 32'h0005,     32'h0007,     1'b0, 32'hFFFE,     1'b1, 1'b0, 1'b0};
    v16[4] = '{1'b1, 32'h8000,     32'h0001,     1'b1, 32'h7FFE,     1'b0, 1'b1, 1'b0};
    v16[5] = '{1'b1, 32'h0007,     32'h0005,     1'b0, 32'h0002,     1'b0, 1'b0, 1'b0};
    v16[6] = '{1'b0, 32'h1234,     32'h4321,     1'b1, 32'h5556,     1'b0, 1'b0, 1'b0};
    v16[7] = '{1'b1, 32'h1234,     32'h1234,     1'b0, 32'h0000,     1'b0, 1'b0, 1'b1};
    v16[8] = '{1'b0, 32'h8000,     32'h8000,     1'b0, 32'h0000,     1'b1, 1'b1, 1'b1};

    v32[0] = '{1'b0, 32'h0000007F, 32'h0000007F, 1'b0, 32'h000000FE, 1'b0, 1'b0, 1'b0};
    v32[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    v32[2] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    v32[3] = '{1'b1, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    v32[4] = '{1'b1, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFE, 1'b0, 1'b1, 1'b0};
    v32[5] = '{1'b1, 32'h00000007, 32'h00000005, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
    v32[6] = '{1'b0, 32'h12345678, 32'h87654321, 1'b1, 32'h9999999A, 1'b0, 1'b0, 1'b0};
    v32[7] = '{1'b1, 32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    v32[8] = '{1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0; en = 1'b1; sub = 1'b0; c_in = 1'b0;
    A16 = '0; B16 = '0; A32 = '0; B32 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;

    // Reset state (en was high during reset and must have been ignored)
    chk("rst_ready", {29'd0, rdy_a, rdy_b, rdy_c}, 32'd7);
    chk("rst_out16x4", {16'd0, o_a}, 32'd0);
    chk("rst_flg16x4", {29'd0, co_a, v_a, z_a}, 32'd0);
    chk("rst_out32x8", o_c, 32'd0);

    for (int i = 0; i < NV; i++) run_op(v16[i], v32[i], i);

    // en held high; operands churn during BUSY and must not disturb the op in flight
    @(negedge clk);
    sub = 1'b0; c_in = 1'b0; A16 = 16'd100; B16 = 16'd23; en = 1'b1;
    @(negedge clk);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (rdy_a) break;
      busy++;
      chk("hold_prev_out", {16'd0, o_a}, 32'h0000);
      A16 = 16'hA5A5 ^ 16'(i); B16 = 16'h5A5A + 16'(i); sub = ~sub; c_in = ~c_in;
      @(negedge clk);
    end
    chk("churn_lat", 32'(busy), 32'd4);
    chk("churn_out", {16'd0, o_a}, 32'd123);
    chk("churn_flg", {29'd0, co_a, v_a, z_a}, 32'd0);
    // ready seen high: these operands are taken at the next edge
    sub = 1'b0; c_in = 1'b0; A16 = 16'd1000; B16 = 16'd1;
    @(negedge clk);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (rdy_a) break;
      busy++;
      chk("hold_out_123", {16'd0, o_a}, 32'd123);
      en = 1'b0; A16 = 16'hFFFF; B16 = 16'hFFFF; sub = 1'b1; c_in = 1'b1;
      @(negedge clk);
    end
    en = 1'b0;
    chk("back2back_lat", 32'(busy), 32'd4);
    chk("back2back_out", {16'd0, o_a}, 32'd1001);

    // Let every unit settle idle before the reset-abort sequence
    repeat (6) @(negedge clk);

    // Reset in the second BUSY cycle aborts the op; outputs go to reset values
    sub = 1'b1; c_in = 1'b0; A16 = 16'd5; B16 = 16'd7; A32 = 32'd5; B32 = 32'd7; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("abort_busy1", {31'd0, rdy_a}, 32'd0);
    @(negedge clk);
    chk("abort_hold_out", {16'd0, o_a}, 32'd1001);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", {29'd0, rdy_a, rdy_b, rdy_c}, 32'd7);
    chk("abort_out16x4", {16'd0, o_a}, 32'd0);
    chk("abort_flg16x4", {29'd0, co_a, v_a, z_a}, 32'd0);
    chk("abort_out32x8", o_c, 32'd0);
    chk("abort_flg32x8", {29'd0, co_c, v_c, z_c}, 32'd0);
    repeat (6) @(negedge clk);
    chk("idle_ready", {31'd0, rdy_a}, 32'd1);
    chk("idle_out", {16'd0, o_a}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
